// File: rtl/mem_stage_if.sv
// Request/response data-memory port between the memory stage and the data memory.
// The master drives the request fields; the slave answers with addr_ok, data_ok and read data.
interface mem_stage_if;
  logic        data_req_o;
  logic        data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o;
  logic [3:0]  data_wstrb_o;
  logic [31:0] data_wdata_o;
  logic        data_addr_ok_i;
  logic        data_data_ok_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o,
    output data_wr_o,
    output data_size_o,
    output data_addr_o,
    output data_wstrb_o,
    output data_wdata_o,
    input  data_addr_ok_i,
    input  data_data_ok_i,
    input  data_rdata_i
  );

  modport slave (
    input  data_req_o,
    input  data_wr_o,
    input  data_size_o,
    input  data_addr_o,
    input  data_wstrb_o,
    input  data_wdata_o,
    output data_addr_ok_i,
    output data_data_ok_i,
    output data_rdata_i
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: runs loads/stores over the req/resp data port, extends load data, builds MEM->WB bus.
// Latency: ALU ops 0 cycles, memory ops >= 3 cycles; stalls in REQ/WAIT unbounded, DONE holds until go.
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic [106:0] exe2mem_bus_ri,
  output logic [69:0]  mem2wb_bus_o,
  input  logic         ctl_mem_valid_i,
  input  logic         ctl_mem2wb_go_i,
  output logic         ctl_mem_over_o,
  output logic [4:0]   ctl_mem_dest_o,
  mem_stage_if.master  dmem
);

  typedef struct packed {
    logic        mem_ld;
    logic        mem_st;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [4:0]  wdest;
    logic        wen;
    logic [31:0] pc;
  } exe2mem_t;

  typedef struct packed {
    logic [4:0]  wdest;
    logic        wen;
    logic [31:0] mem_result;
    logic [31:0] pc;
  } mem2wb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  exe2mem_t    ex;
  mem2wb_t     wb;
  state_t      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        is_mem;
  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  assign ex     = exe2mem_bus_ri;
  assign is_mem = ex.mem_ld | ex.mem_st;
  assign lane   = ex.exe_result[1:0];

  // Load lane select and extension; the bus is held stable by EXE while we wait.
  always_comb begin
    ld_byte = dmem.data_rdata_i[7:0];
    case (lane)
      2'd0:    ld_byte = dmem.data_rdata_i[7:0];
      2'd1:    ld_byte = dmem.data_rdata_i[15:8];
      2'd2:    ld_byte = dmem.data_rdata_i[23:16];
      default: ld_byte = dmem.data_rdata_i[31:24];
    endcase
    ld_half = lane[1] ? dmem.data_rdata_i[31:16] : dmem.data_rdata_i[15:0];
    case (ex.mem_size)
      2'd0:    ld_data = {{24{~ex.mem_unsigned & ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = {{16{~ex.mem_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = dmem.data_rdata_i;
    endcase
  end

  always_comb begin
    case (ex.mem_size)
      2'd0: begin
        st_strb  = 4'b0001 << lane;
        st_wdata = {4{ex.store_data[7:0]}};
      end
      2'd1: begin
        st_strb  = lane[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex.store_data[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = ex.store_data;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (ctl_mem_valid_i && is_mem) state_d = REQ;
      REQ:  if (dmem.data_addr_ok_i) state_d = WAIT;
      WAIT: begin
        if (dmem.data_data_ok_i) begin
          state_d = DONE;
          if (ex.mem_ld) result_d = ld_data;
        end
      end
      DONE: if (ctl_mem2wb_go_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign dmem.data_req_o   = (state_q == REQ);
  assign dmem.data_wr_o    = ex.mem_st;
  assign dmem.data_size_o  = ex.mem_size;
  assign dmem.data_addr_o  = ex.exe_result;
  assign dmem.data_wstrb_o = ex.mem_st ? st_strb : 4'b0000;
  assign dmem.data_wdata_o = st_wdata;

  // ALU ops finish immediately; memory ops only once the response has been captured.
  assign ctl_mem_over_o = ctl_mem_valid_i & (is_mem ? (state_q == DONE) : 1'b1);
  assign ctl_mem_dest_o = ex.wdest & {5{ctl_mem_valid_i}};

  assign wb.wdest      = ex.wdest;
  assign wb.wen        = ex.wen;
  assign wb.mem_result = ex.mem_ld ? result_q : ex.exe_result;
  assign wb.pc         = ex.pc;
  assign mem2wb_bus_o  = wb;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random loads/stores against a byte-lane reference model.
module tb_mem_stage;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [106:0] exe_bus = '0;
  logic [69:0]  wb_bus;
  logic         valid = 1'b0;
  logic         go = 1'b0;
  logic         over;
  logic [4:0]   dest;
  int           checks = 0;
  int           errors = 0;

  mem_stage_if dmem();

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .exe2mem_bus_ri  (exe_bus),
    .mem2wb_bus_o    (wb_bus),
    .ctl_mem_valid_i (valid),
    .ctl_mem2wb_go_i (go),
    .ctl_mem_over_o  (over),
    .ctl_mem_dest_o  (dest),
    .dmem            (dmem)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not end, got running required finished");
    $fatal(1);
  end

  initial begin
    dmem.data_addr_ok_i = 1'b0;
    dmem.data_data_ok_i = 1'b0;
    dmem.data_rdata_i   = 32'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input bit ld, input bit st, input bit [1:0] sz, input bit uns,
                         input bit [31:0] sd, input bit [31:0] addr, input bit [4:0] wd,
                         input bit wen, input bit [31:0] pc);
    exe_bus = {ld, st, sz, uns, sd, addr, wd, wen, pc};
  endtask

  function automatic int nbytes(input int sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
  endfunction

  // Reference: the access covers nbytes starting at the address rounded down to the access size.
  function automatic bit [31:0] ref_load(input bit [31:0] rdata, input bit [31:0] addr,
                                         input int sz, input bit uns);
    int n, start;
    longint unsigned r, v;
    bit [31:0] res;
    n = nbytes(sz);
    start = ((addr % 4) / n) * n;
    r = rdata;
    v = (r >> (8 * start)) % (64'd1 << (8 * n));
    if (!uns && v >= (64'd1 << (8 * n - 1)))
      v = v + (64'd1 << 32) - (64'd1 << (8 * n));
    res = v[31:0];
    return res;
  endfunction

  function automatic bit [3:0] ref_strb(input bit [31:0] addr, input int sz);
    int n, start;
    bit [3:0] s;
    n = nbytes(sz);
    start = ((addr % 4) / n) * n;
    s = 4'b0;
    for (int i = 0; i < 4; i++) if (i >= start && i < start + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic bit [31:0] ref_wdata(input bit [31:0] sd, input int sz);
    int n;
    bit [31:0] w;
    n = nbytes(sz);
    w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  // Plays the memory side of one transaction with chosen delays and stray handshakes,
  // returning what was observed; the calling test decides what is right.
  task automatic run_mem(input bit [31:0] rdata, input int addr_delay, input int data_delay,
                         input int go_delay,
                         output int req_cycles, output bit fields_changed, output bit over_early,
                         output bit done_over, output int latency, output bit [69:0] done_bus,
                         output bit done_changed, output bit [3:0] strb_seen,
                         output bit [31:0] wdata_seen, output bit wr_seen,
                         output bit [31:0] addr_seen, output bit [1:0] size_seen,
                         output bit timeout);
    int c, phase, idle, wait_cnt;
    req_cycles = 0; fields_changed = 0; over_early = 0; done_over = 0; latency = -1;
    done_bus = '0; done_changed = 0; strb_seen = 0; wdata_seen = 0; wr_seen = 0;
    addr_seen = 0; size_seen = 0; timeout = 0;
    c = 0; phase = 0; idle = 0; wait_cnt = 0;
    valid = 1'b1; go = 1'b0;
    dmem.data_addr_ok_i = 1'b0; dmem.data_data_ok_i = 1'b0; dmem.data_rdata_i = $urandom;
    #1;
    over_early |= over;
    while (phase < 2 && !timeout) begin
      step();
      c++;
      dmem.data_addr_ok_i = 1'b0; dmem.data_data_ok_i = 1'b0; dmem.data_rdata_i = $urandom;
      #1;
      over_early |= over;
      if (dmem.data_req_o) begin
        req_cycles++;
        if (req_cycles == 1) begin
          strb_seen = dmem.data_wstrb_o; wdata_seen = dmem.data_wdata_o;
          wr_seen = dmem.data_wr_o; addr_seen = dmem.data_addr_o; size_seen = dmem.data_size_o;
        end else if (strb_seen != dmem.data_wstrb_o || wdata_seen != dmem.data_wdata_o ||
                     wr_seen != dmem.data_wr_o || addr_seen != dmem.data_addr_o ||
                     size_seen != dmem.data_size_o) begin
          fields_changed = 1;
        end
      end
      if (phase == 0) begin
        if (dmem.data_req_o) begin
          if (req_cycles - 1 == addr_delay) begin
            dmem.data_addr_ok_i = 1'b1;
            phase = 1;
          end else begin
            dmem.data_data_ok_i = 1'($urandom_range(0, 1));
          end
        end else begin
          idle++;
          if (idle > 4) timeout = 1;
        end
      end else begin
        if (wait_cnt == data_delay) begin
          dmem.data_data_ok_i = 1'b1;
          dmem.data_rdata_i = rdata;
          phase = 2;
        end else begin
          dmem.data_addr_ok_i = 1'($urandom_range(0, 1));
        end
        wait_cnt++;
      end
      if (c > 200) timeout = 1;
    end
    if (!timeout) begin
      step();
      dmem.data_addr_ok_i = 1'b0; dmem.data_data_ok_i = 1'b0;
      #1;
      done_over = over;
      latency = c + 1;
      done_bus = wb_bus;
      for (int i = 0; i < go_delay; i++) begin
        dmem.data_data_ok_i = 1'($urandom_range(0, 1));
        dmem.data_addr_ok_i = 1'($urandom_range(0, 1));
        dmem.data_rdata_i = $urandom;
        step();
        dmem.data_data_ok_i = 1'b0; dmem.data_addr_ok_i = 1'b0;
        #1;
        if (wb_bus !== done_bus || over !== 1'b1) done_changed = 1;
      end
      go = 1'b1;
      step();
    end
    go = 1'b0; valid = 1'b0;
    dmem.data_addr_ok_i = 1'b0; dmem.data_data_ok_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; valid = 1'b0; go = 1'b0;
    set_bus(1, 0, 2'd2, 0, 32'h0, 32'h0000_1000, 5'd3, 1, 32'h0000_0100);
    repeat (3) step();
    resetn = 1'b1;
    #1;
    checks++; if (dmem.data_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", dmem.data_req_o); end
    checks++; if (over !== 1'b0) begin errors++; $display("FAIL reset_over: got %b required 0", over); end
    checks++; if (dest !== 5'd0) begin errors++; $display("FAIL reset_dest: got %0d required 0", dest); end
    checks++; if (wb_bus[63:32] !== 32'h0) begin errors++; $display("FAIL reset_result: got %h required 00000000", wb_bus[63:32]); end
  endtask

  task automatic test_alu();
    bit [31:0] pc, er;
    bit [4:0] wd;
    bit req_seen;
    set_bus(0, 0, 2'd0, 0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd5, 1, 32'h0000_0400);
    valid = 1'b1;
    #1;
    checks++; if (over !== 1'b1) begin errors++; $display("FAIL alu_over: got %b required 1", over); end
    checks++; if (wb_bus !== {5'd5, 1'b1, 32'h0000_1234, 32'h0000_0400}) begin errors++; $display("FAIL alu_bus: got %h required %h", wb_bus, {5'd5, 1'b1, 32'h0000_1234, 32'h0000_0400}); end
    checks++; if (dest !== 5'd5) begin errors++; $display("FAIL alu_dest: got %0d required 5", dest); end
    req_seen = dmem.data_req_o;
    repeat (3) begin step(); req_seen |= dmem.data_req_o; end
    checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL alu_no_req: got %b required 0", req_seen); end
    for (int i = 0; i < 6; i++) begin
      pc = $urandom; er = $urandom; wd = 5'($urandom);
      set_bus(0, 0, 2'($urandom_range(0, 2)), 1'($urandom), $urandom, er, wd, 1, pc);
      valid = 1'($urandom);
      #1;
      checks++; if (over !== valid) begin errors++; $display("FAIL alu_rand_over: got %b required %b", over, valid); end
      checks++; if (dest !== (valid ? wd : 5'd0)) begin errors++; $display("FAIL alu_rand_dest: got %0d required %0d", dest, valid ? wd : 5'd0); end
      checks++; if (wb_bus[63:32] !== er) begin errors++; $display("FAIL alu_rand_result: got %h required %h", wb_bus[63:32], er); end
      step();
    end
    valid = 1'b0;
    #1;
  endtask

  task automatic test_load_directed();
    bit [1:0] sz [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    bit uns [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit [31:0] expv [4] = '{32'hFFFF_FFF4, 32'h0000_00F4, 32'h0000_12F4, 32'h12F4_5678};
    int rc, lat; bit fc, oe, dov, dc, wr, to; bit [69:0] db; bit [3:0] st; bit [31:0] wdt, ad; bit [1:0] sze;
    for (int i = 0; i < 4; i++) begin
      set_bus(1, 0, sz[i], uns[i], 32'h0, 32'h0000_1002, 5'd7, 1, 32'h0000_0200);
      run_mem(32'h12F4_5678, 0, 0, 0, rc, fc, oe, dov, lat, db, dc, st, wdt, wr, ad, sze, to);
      checks++; if (to || lat != 3 || dov !== 1'b1 || oe) begin errors++; $display("FAIL load_latency[%0d]: got lat=%0d over=%b early=%b timeout=%b required lat=3 over=1 early=0", i, lat, dov, oe, to); end
      checks++; if (db[63:32] !== expv[i]) begin errors++; $display("FAIL load_result[%0d]: got %h required %h", i, db[63:32], expv[i]); end
      checks++; if (st !== 4'b0 || wr !== 1'b0 || rc != 1) begin errors++; $display("FAIL load_req[%0d]: got strb=%b wr=%b req_cycles=%0d required 0000 0 1", i, st, wr, rc); end
    end
  endtask

  task automatic test_store_directed();
    bit [1:0] sz [3] = '{2'd0, 2'd1, 2'd2};
    bit [31:0] addr [3] = '{32'h0000_2003, 32'h0000_2000, 32'h0000_2000};
    bit [31:0] sd [3] = '{32'h0000_00AB, 32'h0000_CDEF, 32'h89AB_CDEF};
    bit [3:0] es [3] = '{4'b1000, 4'b0011, 4'b1111};
    bit [31:0] ew [3] = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'h89AB_CDEF};
    int rc, lat; bit fc, oe, dov, dc, wr, to; bit [69:0] db; bit [3:0] st; bit [31:0] wdt, ad; bit [1:0] sze;
    for (int i = 0; i < 3; i++) begin
      set_bus(0, 1, sz[i], 0, sd[i], addr[i], 5'd9, 0, 32'h0000_0300);
      run_mem(32'h0, 0, 0, 0, rc, fc, oe, dov, lat, db, dc, st, wdt, wr, ad, sze, to);
      checks++; if (wr !== 1'b1 || st !== es[i] || wdt !== ew[i]) begin errors++; $display("FAIL store_req[%0d]: got wr=%b strb=%b wdata=%h required 1 %b %h", i, wr, st, wdt, es[i], ew[i]); end
      checks++; if (to || lat != 3 || db !== {5'd9, 1'b0, addr[i], 32'h0000_0300}) begin errors++; $display("FAIL store_done[%0d]: got lat=%0d bus=%h required lat=3 bus=%h", i, lat, db, {5'd9, 1'b0, addr[i], 32'h0000_0300}); end
    end
  endtask

  task automatic test_stall();
    int rc, lat; bit fc, oe, dov, dc, wr, to; bit [69:0] db; bit [3:0] st; bit [31:0] wdt, ad; bit [1:0] sze;
    set_bus(1, 0, 2'd2, 0, 32'h0, 32'h0000_4008, 5'd12, 1, 32'h0000_0500);
    run_mem(32'hCAFE_F00D, 4, 3, 2, rc, fc, oe, dov, lat, db, dc, st, wdt, wr, ad, sze, to);
    checks++; if (rc != 5 || fc) begin errors++; $display("FAIL stall_req: got req_cycles=%0d changed=%b required 5 0", rc, fc); end
    checks++; if (oe || dov !== 1'b1 || lat != 10 || to) begin errors++; $display("FAIL stall_over: got early=%b over=%b lat=%0d required 0 1 10", oe, dov, lat); end
    checks++; if (dc || db !== {5'd12, 1'b1, 32'hCAFE_F00D, 32'h0000_0500}) begin errors++; $display("FAIL stall_hold: got changed=%b bus=%h required 0 %h", dc, db, {5'd12, 1'b1, 32'hCAFE_F00D, 32'h0000_0500}); end
  endtask

  task automatic test_reset_mid();
    int rc, lat; bit fc, oe, dov, dc, wr, to; bit [69:0] db; bit [3:0] st; bit [31:0] wdt, ad; bit [1:0] sze;
    set_bus(1, 0, 2'd2, 0, 32'h0, 32'h0000_3000, 5'd4, 1, 32'h0000_0600);
    valid = 1'b1;
    step();
    dmem.data_addr_ok_i = 1'b1;
    step();
    dmem.data_addr_ok_i = 1'b0;
    resetn = 1'b0; valid = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    checks++; if (dmem.data_req_o !== 1'b0) begin errors++; $display("FAIL midreset_req: got %b required 0", dmem.data_req_o); end
    dmem.data_data_ok_i = 1'b1; dmem.data_rdata_i = 32'hDEAD_BEEF;
    step();
    dmem.data_data_ok_i = 1'b0;
    #1;
    checks++; if (dmem.data_req_o !== 1'b0 || wb_bus[63:32] !== 32'h0) begin errors++; $display("FAIL midreset_stray: got req=%b result=%h required 0 00000000", dmem.data_req_o, wb_bus[63:32]); end
    run_mem(32'h55AA_1234, 1, 1, 0, rc, fc, oe, dov, lat, db, dc, st, wdt, wr, ad, sze, to);
    checks++; if (to || lat != 5 || db[63:32] !== 32'h55AA_1234) begin errors++; $display("FAIL midreset_next: got lat=%0d result=%h required 5 55aa1234", lat, db[63:32]); end
  endtask

  task automatic test_back_to_back();
    int rc, lat; bit fc, oe, dov, dc, wr, to; bit [69:0] db; bit [3:0] st; bit [31:0] wdt, ad; bit [1:0] sze;
    set_bus(1, 0, 2'd1, 1, 32'h0, 32'h0000_5002, 5'd1, 1, 32'h0000_0700);
    run_mem(32'h8765_4321, 0, 0, 0, rc, fc, oe, dov, lat, db, dc, st, wdt, wr, ad, sze, to);
    set_bus(1, 0, 2'd0, 0, 32'h0, 32'h0000_5001, 5'd2, 1, 32'h0000_0704);
    run_mem(32'h0000_8000, 0, 0, 0, rc, fc, oe, dov, lat, db, dc, st, wdt, wr, ad, sze, to);
    checks++; if (to || lat != 3 || db[63:32] !== 32'hFFFF_FF80) begin errors++; $display("FAIL b2b_second: got lat=%0d result=%h required 3 ffffff80", lat, db[63:32]); end
  endtask

  task automatic test_random();
    int rc, lat; bit fc, oe, dov, dc, wr, to; bit [69:0] db; bit [3:0] st; bit [31:0] wdt, ad; bit [1:0] sze;
    bit ld, uns, wen; int sz, adl, ddl, gdl; bit [31:0] addr, sd, rdata, pc, er; bit [4:0] wd;
    for (int i = 0; i < 40; i++) begin
      ld = 1'($urandom); sz = $urandom_range(0, 2); uns = 1'($urandom);
      addr = $urandom; sd = $urandom; rdata = $urandom; pc = $urandom; wd = 5'($urandom);
      wen = ld ? 1'b1 : 1'b0;
      adl = $urandom_range(0, 3); ddl = $urandom_range(0, 3); gdl = $urandom_range(0, 2);
      set_bus(ld, !ld, 2'(sz), uns, sd, addr, wd, wen, pc);
      run_mem(rdata, adl, ddl, gdl, rc, fc, oe, dov, lat, db, dc, st, wdt, wr, ad, sze, to);
      er = ld ? ref_load(rdata, addr, sz, uns) : addr;
      checks++; if (db !== {wd, wen, er, pc}) begin errors++; $display("FAIL rand_bus[%0d]: got %h required %h", i, db, {wd, wen, er, pc}); end
      checks++; if (to || lat != 3 + adl + ddl || oe || dov !== 1'b1 || dc) begin errors++; $display("FAIL rand_timing[%0d]: got lat=%0d early=%b over=%b changed=%b required lat=%0d 0 1 0", i, lat, oe, dov, dc, 3 + adl + ddl); end
      checks++; if (rc != adl + 1 || fc || ad !== addr || sze !== 2'(sz) || wr !== !ld) begin errors++; $display("FAIL rand_req[%0d]: got req=%0d changed=%b addr=%h size=%0d wr=%b required %0d 0 %h %0d %b", i, rc, fc, ad, sze, wr, adl + 1, addr, sz, !ld); end
      checks++; if (st !== (ld ? 4'b0 : ref_strb(addr, sz)) || (!ld && wdt !== ref_wdata(sd, sz))) begin errors++; $display("FAIL rand_store[%0d]: got strb=%b wdata=%h required %b %h", i, st, wdt, ld ? 4'b0 : ref_strb(addr, sz), ref_wdata(sd, sz)); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_directed();
    test_store_directed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, sitting between the execute stage and the write-back stage. It unpacks the EXE→MEM bus and runs loads and stores over a request/response data-memory interface with a small state machine. It applies byte strobes and sign/zero extension, and presents the MEM→WB bus plus pipeline-control valid/over/dest signals. It holds its result stable until the pipeline controller advances the instruction into WB.

## Interface
Parameters: none. Bus widths come from `common.vh`: `EXE2MEMBusSize` = 107, `MEM2WBBusSize` = 70, `RegAddrBusW` = 5.

- clk  in  1  single clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- exe2mem_bus_ri  in  107  {mem_ld, mem_st, mem_size[1:0], mem_unsigned, store_data[31:0], exe_result[31:0], wdest[4:0], wen, pc[31:0]}, MSB first
  - mem_size encoding: 0 = byte, 1 = half, 2 = word
  - exe_result is the data address for memory operations
- mem2wb_bus_o  out  70  {wdest, wen, mem_result[31:0], pc}, registered by the pipeline controller
- ctl_mem_valid_i  in  1  stage holds a valid instruction
- ctl_mem2wb_go_i  in  1  controller moves this instruction into WB this cycle
- ctl_mem_over_o  out  1  stage result is final
- ctl_mem_dest_o  out  5  wdest AND {5{ctl_mem_valid_i}}, for hazard detection
- data_req_o  out  1  memory request
- data_wr_o  out  1  1 = store
- data_size_o  out  2  equals mem_size
- data_addr_o  out  32  exe_result, passed unmodified
- data_wstrb_o  out  4  byte enables; 0 for loads
- data_wdata_o  out  32  replicated store data
- data_addr_ok_i  in  1  request accepted
- data_data_ok_i  in  1  read data returned or write completed
- data_rdata_i  in  32  read data, valid with data_data_ok_i

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE → REQ: ctl_mem_valid_i & (mem_ld | mem_st).
  - REQ → WAIT: data_addr_ok_i.
  - WAIT → DONE: data_data_ok_i. Load result is captured into a 32-bit result register on this edge.
  - DONE → IDLE: ctl_mem2wb_go_i.
- data_req_o = (state == REQ). Request fields are combinational from the bus and held stable while in REQ.
- Non-memory instruction: stays in IDLE.
  - ctl_mem_over_o = ctl_mem_valid_i, combinationally.
  - mem_result = exe_result.
- Memory instruction: ctl_mem_over_o = (state == DONE).
  - Load: mem_result = result register.
  - Store: mem_result = exe_result; wen comes from the bus (EXE clears it for stores).
- Load extraction, with a = addr[1:0]:
  - byte: lane a.
  - half: lane addr[1]; addr[0] is ignored.
  - word: full word; a is ignored.
  - Sign-extend unless mem_unsigned = 1, then zero-extend.
- Store strobes:
  - byte: 1 << a; wdata = {4{store_data[7:0]}}.
  - half: addr[1] ? 1100 : 0011; wdata = {2{store_data[15:0]}}.
  - word: 1111; wdata = store_data.
- Alignment is EXE's responsibility. No exception is raised here.
- data_data_ok_i arriving in IDLE, REQ or DONE is ignored.
- data_addr_ok_i outside REQ is ignored.

## Timing
- Reset (resetn = 0 at an edge):
  - state = IDLE, result register = 0.
  - Next cycle: data_req_o = 0 and data_wstrb_o is don't-care.
  - Reset mid-transaction abandons it; any late data_ok is dropped.
- ctl_mem_over_o and ctl_mem_dest_o are 0 whenever ctl_mem_valid_i = 0.
- Non-memory latency: 0 cycles.
- Memory latency, with valid first seen at cycle 0:
  - Request is issued at cycle 1.
  - over rises the cycle after data_ok.
  - Minimum is cycle 3 (addr_ok at 1, data_ok at 2). The interface guarantees data_ok never arrives in the same cycle as its own addr_ok.
- Stall in REQ or WAIT is unbounded. Outputs hold; over stays 0.
- DONE holds mem2wb_bus_o and over stable until go.
- go while over = 0 is illegal; the controller never issues it.
- go in DONE returns to IDLE on that edge. A new valid memory instruction at the next cycle issues its request the cycle after, with no bubble lost in IDLE.

## Test plan
- ALU op: exe_result = 0x0000_1234, wdest = 5, wen = 1, valid = 1 → over = 1 same cycle; mem2wb mem_result = 0x1234; dest = 5; data_req_o stays 0.
- lb, addr = 0x1002, rdata = 0x12F45678, addr_ok at cycle 1, data_ok at cycle 2 → over at cycle 3; mem_result = 0xFFFF_FFF4. Repeat with lbu → 0x0000_00F4.
- lh, addr = 0x1002, same rdata → 0x0000_12F4. lw → 0x12F4_5678.
- sb, addr = 0x2003, store_data = 0x0000_00AB → data_wr_o = 1, wstrb = 1000, wdata = 0xABAB_ABAB. sh at 0x2000 → wstrb = 0011. sw → wstrb = 1111.
- Stalls: addr_ok delayed 4 cycles, data_ok delayed 3 further → data_req_o held 5 cycles with fields stable; over held 0 until data_ok; in DONE, go withheld 2 cycles → bus unchanged.
- resetn low while in WAIT, then a stray data_ok after reset → state IDLE, data_req_o = 0; stray data_ok ignored; next lw completes normally.
